// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-transfer encodings,
// reset vector and the PC redirect FSM states.
package pipe_pkg;

  localparam logic [1:0] JT_NONE = 2'b00;
  localparam logic [1:0] JT_BR   = 2'b01;
  localparam logic [1:0] JT_J    = 2'b10;
  localparam logic [1:0] JT_JR   = 2'b11;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

  typedef enum logic {
    PCS_RUN  = 1'b0,
    PCS_HOLD = 1'b1
  } pc_state_e;

  typedef struct packed {
    logic [31:0] target;
    logic        err;
  } npc_t;

endpackage

// File: rtl/npc_calc.sv
// Next-PC target computation for branches and jumps.
// Purely combinational; also usable for link-address logic.
module npc_calc
  import pipe_pkg::*;
(
  input  logic [1:0]  jtype,
  input  logic [31:0] pc4_id,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] jr_target,
  output logic [31:0] target,
  output logic        err_nx
);

  logic [31:0] br_off;

  assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    target = '0;
    err_nx = 1'b0;
    unique case (jtype)
      JT_BR: target = pc4_id + br_off;
      JT_J:  target = {pc4_id[31:28], imm26, 2'b00};
      JT_JR: begin
        target = {jr_target[31:2], 2'b00};
        err_nx = |jr_target[1:0];
      end
      default: target = '0;
    endcase
  end

endmodule

// File: rtl/pc_redirect.sv
// Fetch PC register with delay-slot branch/jump redirect and
// a one-entry hold register for targets resolved while fetch stalls.
module pc_redirect
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        br_valid,
  input  logic [1:0]  jtype,
  input  logic        cmp_out,
  input  logic [31:0] pc4_id,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        hold,
  output logic        redirect,
  output logic        addr_err
);

  pc_state_e   state, state_nx;
  logic [31:0] pc_q, pc_nx;
  npc_t        held, held_nx;
  logic        redir_q, redir_nx;
  logic        aerr_q, aerr_nx;

  logic        adv;
  logic        take;
  logic        cond;
  logic [31:0] tgt;
  logic        tgt_err;

  npc_calc u_npc (
    .jtype     (jtype),
    .pc4_id    (pc4_id),
    .imm16     (imm16),
    .imm26     (imm26),
    .jr_target (jr_target),
    .target    (tgt),
    .err_nx    (tgt_err)
  );

  assign adv  = imem_ready & ~stall;
  assign cond = (jtype == JT_BR) ? cmp_out
                                 : (jtype != JT_NONE);
  assign take = br_valid & ~stall & cond;

  always_comb begin
    state_nx = state;
    pc_nx    = pc_q;
    held_nx  = held;
    redir_nx = 1'b0;
    aerr_nx  = 1'b0;
    unique case (state)
      PCS_RUN: begin
        if (take && adv) begin
          pc_nx    = tgt;
          redir_nx = 1'b1;
          aerr_nx  = tgt_err;
        end else if (take) begin
          held_nx  = '{target: tgt, err: tgt_err};
          state_nx = PCS_HOLD;
        end else if (adv) begin
          pc_nx = pc_plus4;
        end
      end
      // A control transfer in the delay slot is illegal; ignore it.
      PCS_HOLD: begin
        if (adv) begin
          pc_nx    = held.target;
          redir_nx = 1'b1;
          aerr_nx  = held.err;
          held_nx  = '0;
          state_nx = PCS_RUN;
        end
      end
      default: state_nx = PCS_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= PCS_RUN;
      pc_q    <= RESET_PC;
      held    <= '0;
      redir_q <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      pc_q    <= pc_nx;
      held    <= held_nx;
      redir_q <= redir_nx;
      aerr_q  <= aerr_nx;
    end
  end

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;
  assign hold     = (state == PCS_HOLD);
  assign redirect = redir_q;
  assign addr_err = aerr_q;

endmodule
